// File: rtl/uart_imem_loader.sv
// -----------------------------------------------------------------------------
// uart_imem_loader
//
// Boot loader that sits in front of the instruction memory. It receives a
// program over the RsRx UART line (8N1, LSB first) and packs the bytes into
// 32-bit little-endian words. It writes those words to consecutive
// instruction-memory word addresses. The CPU is held in reset (cpu_hold) until
// the declared number of words has arrived.
//
// Packet: LEN_LO, LEN_HI (N = 16-bit word count), then N*4 data bytes. The
// first byte of each word lands in wdata[7:0].
//
// Parameters
//   CLK_FREQ    clk frequency in Hz
//   BAUD        UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD, must be >= 8
//   ADDR_WIDTH  instruction-memory word-address width (16 or less)
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high
//   RsRx        UART receive line, idles high, asynchronous to clk
//   imem_we     one-cycle write strobe to instruction memory
//   imem_addr   word address for the write (stable while imem_we=1)
//   imem_wdata  word for the write (stable while imem_we=1)
//   cpu_hold    1 = keep CPU in reset, 0 = program loaded
//   load_done   1 once all declared words have been received
//   frame_err   sticky, set on any bad stop bit
//   overflow    sticky, set when the word count exceeds 2**ADDR_WIDTH
// -----------------------------------------------------------------------------
module uart_imem_loader #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RsRx,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int TIMER_W      = $clog2(CLKS_PER_BIT);

  // The timer restarts at 0 on every state change. A tick therefore falls on
  // the last count of each interval.
  localparam logic [TIMER_W-1:0] FULL_TICK = TIMER_W'(CLKS_PER_BIT - 1);
  localparam logic [TIMER_W-1:0] HALF_TICK = TIMER_W'(CLKS_PER_BIT / 2 - 1);

  // Memory depth widened by one bit so that 2**16 can still be compared
  // against the 16-bit word counter.
  localparam logic [16:0] DEPTH = 17'(1 << ADDR_WIDTH);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  typedef enum logic [1:0] {
    LD_LEN0,
    LD_LEN1,
    LD_DATA,
    LD_DONE
  } ld_state_e;

  // ---------------------------------------------------------------------------
  // RsRx synchroniser. The flops reset to 1 (idle line), so leaving reset can
  // never look like a start bit.
  // ---------------------------------------------------------------------------
  logic rx_sync1_q;
  logic rx_sync2_q;

  // NOTE: every clocked block uses non-blocking assignments. Each flop then
  //       samples the value from before the edge, which is what makes this
  //       two-stage chain a real two-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
    end else begin
      rx_sync1_q <= RsRx;
      rx_sync2_q <= rx_sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // RX FSM
  // ---------------------------------------------------------------------------
  rx_state_e            rx_state_q, rx_state_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic                 frame_err_q, frame_err_d;
  logic                 byte_valid;
  logic [7:0]           rx_byte;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rx_state_q <= RX_IDLE;
    else       rx_state_q <= rx_state_d;
  end

  // Next-state logic
  always_comb begin
    // NOTE: the default assignment comes first, so every path assigns the
    //       signal and no latch is inferred.
    rx_state_d = rx_state_q;
    case (rx_state_q)
      RX_IDLE:  if (!rx_sync2_q) rx_state_d = RX_START;
      RX_START: if (timer_q == HALF_TICK)
                  rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;  // high = glitch
      RX_DATA:  if (timer_q == FULL_TICK && bit_cnt_q == 3'd7)
                  rx_state_d = RX_STOP;
      RX_STOP:  if (timer_q == FULL_TICK) rx_state_d = RX_IDLE;
      default:  rx_state_d = RX_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    timer_d     = timer_q + TIMER_W'(1);
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    frame_err_d = frame_err_q;
    byte_valid  = 1'b0;
    case (rx_state_q)
      RX_IDLE: timer_d = '0;
      RX_START: begin
        if (timer_q == HALF_TICK) begin
          timer_d   = '0;
          bit_cnt_d = '0;
        end
      end
      RX_DATA: begin
        if (timer_q == FULL_TICK) begin
          timer_d   = '0;
          // LSB arrives first. Shift in from the top, so after 8 samples the
          // first bit sits in bit 0.
          shift_d   = {rx_sync2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      RX_STOP: begin
        if (timer_q == FULL_TICK) begin
          timer_d = '0;
          if (rx_sync2_q) byte_valid  = 1'b1;
          else            frame_err_d = 1'b1;
        end
      end
      default: timer_d = '0;
    endcase
  end

  assign rx_byte = shift_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Loader FSM (advances only on byte_valid)
  // ---------------------------------------------------------------------------
  ld_state_e             ld_state_q, ld_state_d;
  logic [15:0]           len_q, len_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           word_q, word_d;
  logic [15:0]           wcnt_q, wcnt_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic                  overflow_q, overflow_d;
  logic                  load_done_q;
  logic                  cpu_hold_q;
  logic                  word_complete;
  logic                  in_range;

  assign word_complete = (ld_state_q == LD_DATA) && byte_valid &&
                         (byte_cnt_q == 2'd3);
  assign in_range      = ({1'b0, wcnt_q} < DEPTH);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ld_state_q <= LD_LEN0;
    else       ld_state_q <= ld_state_d;
  end

  // Next-state logic
  always_comb begin
    ld_state_d = ld_state_q;
    case (ld_state_q)
      LD_LEN0: if (byte_valid) ld_state_d = LD_LEN1;
      LD_LEN1: if (byte_valid)
                 ld_state_d = ({rx_byte, len_q[7:0]} == 16'd0) ? LD_DONE : LD_DATA;
      // Entering DONE on the same edge that raises the last strobe makes
      // load_done and the final imem_we coincide.
      LD_DATA: if (word_complete && (wcnt_q + 16'd1 == len_q))
                 ld_state_d = LD_DONE;
      LD_DONE: ld_state_d = LD_DONE;  // only reset leaves DONE
      default: ld_state_d = LD_LEN0;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    wcnt_d     = wcnt_q;
    we_d       = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    overflow_d = overflow_q;
    case (ld_state_q)
      LD_LEN0: if (byte_valid) len_d[7:0]  = rx_byte;
      LD_LEN1: if (byte_valid) len_d[15:8] = rx_byte;
      LD_DATA: begin
        if (byte_valid) begin
          // Little-endian. Each byte enters at the top, so after four bytes
          // the first one has reached bits [7:0].
          word_d     = {rx_byte, word_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            wcnt_d = wcnt_q + 16'd1;
            if (in_range) begin
              // Address and data change only here. They stay put for at
              // least the next four byte times, which covers the strobe.
              we_d    = 1'b1;
              addr_d  = wcnt_q[ADDR_WIDTH-1:0];
              wdata_d = word_d;
            end else begin
              overflow_d = 1'b1;  // word is consumed but never written
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      len_q       <= '0;
      byte_cnt_q  <= '0;
      word_q      <= '0;
      wcnt_q      <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      overflow_q  <= 1'b0;
      load_done_q <= 1'b0;
      cpu_hold_q  <= 1'b1;
    end else begin
      len_q       <= len_d;
      byte_cnt_q  <= byte_cnt_d;
      word_q      <= word_d;
      wcnt_q      <= wcnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      overflow_q  <= overflow_d;
      // Status flags are registered from the next state. They rise on the
      // same edge as DONE is entered and never glitch.
      load_done_q <= (ld_state_d == LD_DONE);
      cpu_hold_q  <= (ld_state_d != LD_DONE);
    end
  end

  assign imem_we    = we_q;
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign load_done  = load_done_q;
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_imem_loader.sv
// -----------------------------------------------------------------------------
// Testbench for uart_imem_loader.
//
// dut_a uses ADDR_WIDTH=10 and dut_b uses ADDR_WIDTH=2. Both run at 16 clocks
// per bit. Expected writes are pushed into a queue for each DUT. A monitor pops
// an entry on every imem_we and compares it.
// -----------------------------------------------------------------------------
module tb_uart_imem_loader;

  localparam int CLK_FREQ = 1_600_000;
  localparam int BAUD     = 100_000;

  logic        clk = 1'b0;
  logic        rst_a = 1'b1;
  logic        rst_b = 1'b1;
  logic [1:0]  rx = 2'b11;

  logic        we_a, hold_a, done_a, ferr_a, ovf_a;
  logic [9:0]  addr_a;
  logic [31:0] wdata_a;
  logic        we_b, hold_b, done_b, ferr_b, ovf_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;

  always #5 clk = ~clk;

  uart_imem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(10)) dut_a (
    .clk(clk), .reset(rst_a), .RsRx(rx[0]),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .cpu_hold(hold_a), .load_done(done_a), .frame_err(ferr_a), .overflow(ovf_a)
  );

  uart_imem_loader #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .ADDR_WIDTH(2)) dut_b (
    .clk(clk), .reset(rst_b), .RsRx(rx[1]),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .cpu_hold(hold_b), .load_done(done_b), .frame_err(ferr_b), .overflow(ovf_b)
  );

  typedef struct packed {
    logic [9:0]  addr;
    logic [31:0] data;
    logic        done;
  } wr_t;

  wr_t exp_a[$];
  wr_t exp_b[$];
  wr_t mon_a;
  wr_t mon_b;
  int  vectors     = 0;
  int  miscompares = 0;
  int  writes_a    = 0;
  int  writes_b    = 0;
  event stop_ev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (we_a) begin
      writes_a++;
      if (exp_a.size() == 0) begin
        check("a_unexpected_we", 32'(we_a), 32'd0);
      end else begin
        mon_a = exp_a.pop_front();
        check("a_addr", 32'(addr_a), 32'(mon_a.addr));
        check("a_wdata", wdata_a, mon_a.data);
        check("a_done_with_we", 32'(done_a), 32'(mon_a.done));
        check("a_hold_with_we", 32'(hold_a), 32'(!mon_a.done));
      end
    end
    if (we_b) begin
      writes_b++;
      if (exp_b.size() == 0) begin
        check("b_unexpected_we", 32'(we_b), 32'd0);
      end else begin
        mon_b = exp_b.pop_front();
        check("b_addr", 32'(addr_b), 32'(mon_b.addr));
        check("b_wdata", wdata_b, mon_b.data);
        check("b_done_with_we", 32'(done_b), 32'(mon_b.done));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_byte(input int sel, input logic [7:0] b, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx[sel] = frame[i];
      if (i == 9) -> stop_ev;
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    rx[sel] = 1'b1;
  endtask

  task automatic send_word(input int sel, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] t;
      t = w >> (8 * i);
      send_byte(sel, t[7:0], 1'b1);
    end
  endtask

  task automatic expect_a(input logic [9:0] addr, input logic [31:0] data, input logic done);
    wr_t e;
    e.addr = addr; e.data = data; e.done = done;
    exp_a.push_back(e);
  endtask

  task automatic expect_b(input logic [9:0] addr, input logic [31:0] data, input logic done);
    wr_t e;
    e.addr = addr; e.data = data; e.done = done;
    exp_b.push_back(e);
  endtask

  task automatic pulse_reset_a();
    @(negedge clk);
    rst_a = 1'b1;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    writes_a = 0;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_hold_a", 32'(hold_a), 32'd1);
    check("rst_done_a", 32'(done_a), 32'd0);
    check("rst_we_a", 32'(we_a), 32'd0);
    check("rst_hold_b", 32'(hold_b), 32'd1);
    check("rst_ovf_b", 32'(ovf_b), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    repeat (4) @(negedge clk);

    // 1: three-word program
    expect_a(10'd0, 32'h0050_0093, 1'b0);
    expect_a(10'd1, 32'h0070_0113, 1'b0);
    expect_a(10'd2, 32'h0020_81B3, 1'b1);
    send_byte(0, 8'h03, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_word(0, 32'h0050_0093);
    send_word(0, 32'h0070_0113);
    send_word(0, 32'h0020_81B3);
    repeat (4) @(negedge clk);
    check("t1_writes", 32'(writes_a), 32'd3);
    check("t1_done", 32'(done_a), 32'd1);
    check("t1_hold", 32'(hold_a), 32'd0);
    check("t1_ferr", 32'(ferr_a), 32'd0);

    // 2: N=0, done the cycle after LEN_HI's stop sample
    pulse_reset_a();
    send_byte(0, 8'h00, 1'b1);
    fork
      send_byte(0, 8'h00, 1'b1);
      begin
        @(stop_ev);
        repeat (10) @(negedge clk);
        check("t2_done_before", 32'(done_a), 32'd0);
        @(negedge clk);
        check("t2_done_after", 32'(done_a), 32'd1);
        check("t2_hold_after", 32'(hold_a), 32'd0);
      end
    join
    repeat (4) @(negedge clk);
    check("t2_writes", 32'(writes_a), 32'd0);

    // 3: bad stop bit on a data byte, then resend
    pulse_reset_a();
    expect_a(10'd0, 32'h1234_5678, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'h78, 1'b1);
    send_byte(0, 8'h56, 1'b0);
    repeat (32) @(negedge clk);
    check("t3_ferr", 32'(ferr_a), 32'd1);
    check("t3_done_mid", 32'(done_a), 32'd0);
    send_byte(0, 8'h56, 1'b1);
    send_byte(0, 8'h34, 1'b1);
    send_byte(0, 8'h12, 1'b1);
    repeat (4) @(negedge clk);
    check("t3_writes", 32'(writes_a), 32'd1);
    check("t3_done", 32'(done_a), 32'd1);

    // 4: 3-clock glitch while idle must not count as a byte
    pulse_reset_a();
    @(negedge clk);
    rx[0] = 1'b0;
    repeat (3) @(negedge clk);
    rx[0] = 1'b1;
    repeat (64) @(negedge clk);
    check("t4_ferr", 32'(ferr_a), 32'd0);
    check("t4_done", 32'(done_a), 32'd0);
    expect_a(10'd0, 32'hDEAD_BEEF, 1'b1);
    send_byte(0, 8'h01, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_word(0, 32'hDEAD_BEEF);
    repeat (4) @(negedge clk);
    check("t4_writes", 32'(writes_a), 32'd1);
    check("t4_done_after", 32'(done_a), 32'd1);

    // 5: reset in the middle of word 1, then full reload
    pulse_reset_a();
    expect_a(10'd0, 32'h1122_3344, 1'b0);
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'hAA, 1'b0);
    repeat (32) @(negedge clk);
    send_word(0, 32'h1122_3344);
    send_byte(0, 8'h66, 1'b1);
    send_byte(0, 8'h55, 1'b1);
    check("t5_ferr_pre", 32'(ferr_a), 32'd1);
    check("t5_wdata_pre", wdata_a, 32'h1122_3344);
    #2;
    rst_a = 1'b1;
    #1;
    check("t5_hold", 32'(hold_a), 32'd1);
    check("t5_done", 32'(done_a), 32'd0);
    check("t5_ferr", 32'(ferr_a), 32'd0);
    check("t5_ovf", 32'(ovf_a), 32'd0);
    check("t5_we", 32'(we_a), 32'd0);
    check("t5_addr", 32'(addr_a), 32'd0);
    check("t5_wdata", wdata_a, 32'd0);
    @(negedge clk);
    rst_a = 1'b0;
    writes_a = 0;
    expect_a(10'd0, 32'hA1B2_C3D4, 1'b0);
    expect_a(10'd1, 32'h0BAD_F00D, 1'b1);
    send_byte(0, 8'h02, 1'b1);
    send_byte(0, 8'h00, 1'b1);
    send_word(0, 32'hA1B2_C3D4);
    send_word(0, 32'h0BAD_F00D);
    repeat (4) @(negedge clk);
    check("t5_writes", 32'(writes_a), 32'd2);
    check("t5_done_after", 32'(done_a), 32'd1);

    // 6: ADDR_WIDTH=2, N=5 -> overflow on the 5th word
    send_byte(1, 8'h05, 1'b1);
    send_byte(1, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      expect_b(10'(i), 32'hC0DE_0000 + 32'(i), 1'b0);
      send_word(1, 32'hC0DE_0000 + 32'(i));
    end
    repeat (4) @(negedge clk);
    check("t6_ovf_before", 32'(ovf_b), 32'd0);
    check("t6_done_before", 32'(done_b), 32'd0);
    send_word(1, 32'hC0DE_0004);
    repeat (4) @(negedge clk);
    check("t6_ovf", 32'(ovf_b), 32'd1);
    check("t6_done", 32'(done_b), 32'd1);
    check("t6_hold", 32'(hold_b), 32'd0);
    send_word(1, 32'h0403_0201);
    send_byte(1, 8'h05, 1'b1);
    send_byte(1, 8'h00, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_writes", 32'(writes_b), 32'd4);
    check("t6_done_kept", 32'(done_b), 32'd1);

    check("a_queue_empty", 32'(exp_a.size()), 32'd0);
    check("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
